// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, Val2 generator, ALU with NZCV flags, status register,
// branch target adder and the EXE/MEM output register.
// Optional feature: define MUL_EN to add a 32-iteration shift-add multiplier on opcode 1010.
module exe_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             freeze,
   input  logic [WIDTH-1:0] pc_in,
   input  logic             b_in,
   input  logic             s_in,
   input  logic             mem_r_en_in,
   input  logic             mem_w_en_in,
   input  logic             wb_en_in,
   input  logic             imm_in,
   input  logic [3:0]       exe_cmd_in,
   input  logic [3:0]       status_in,
   input  logic [23:0]      signed_imm_24_in,
   input  logic [11:0]      shift_operand_in,
   input  logic [3:0]       dest_in,
   input  logic [WIDTH-1:0] val_rn_in,
   input  logic [WIDTH-1:0] val_rm_in,
   input  logic [1:0]       fwd_sel_rn,
   input  logic [1:0]       fwd_sel_rm,
   input  logic [WIDTH-1:0] wb_value,
   output logic             branch_taken,
   output logic [WIDTH-1:0] branch_addr,
   output logic [3:0]       status_out,
   output logic [WIDTH-1:0] alu_res,
   output logic [WIDTH-1:0] st_val,
   output logic [3:0]       dest,
   output logic             wb_en,
   output logic             mem_r_en,
   output logic             mem_w_en,
   output logic             mul_busy
);

   localparam logic [3:0] OpMov = 4'b0001;
   localparam logic [3:0] OpAdd = 4'b0010;
   localparam logic [3:0] OpAdc = 4'b0011;
   localparam logic [3:0] OpSub = 4'b0100;
   localparam logic [3:0] OpSbc = 4'b0101;
   localparam logic [3:0] OpAnd = 4'b0110;
   localparam logic [3:0] OpOrr = 4'b0111;
   localparam logic [3:0] OpEor = 4'b1000;
   localparam logic [3:0] OpMvn = 4'b1001;

   logic [WIDTH-1:0] alu_res_q, st_val_q;
   logic [3:0]       dest_q, status_q;
   logic             wb_en_q, mem_r_en_q, mem_w_en_q;

   logic [WIDTH-1:0] rn_f, rm_f, val2;
   logic [WIDTH-1:0] alu_out, exe_res;
   logic             alu_c, alu_v;
   logic [3:0]       flags;
   logic             mul_done;
   logic [WIDTH-1:0] mul_res;
   logic             pipe_load;

   // Branch target is purely combinational so fetch can redirect in the same cycle.
   assign branch_taken = b_in;
   assign branch_addr  = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

   // Operand forwarding; select 01 reads back the held EXE/MEM result.
   always_comb begin
      rn_f = val_rn_in;
      rm_f = val_rm_in;
      case (fwd_sel_rn)
         2'b01:   rn_f = alu_res_q;
         2'b10:   rn_f = wb_value;
         default: rn_f = val_rn_in;
      endcase
      case (fwd_sel_rm)
         2'b01:   rm_f = alu_res_q;
         2'b10:   rm_f = wb_value;
         default: rm_f = val_rm_in;
      endcase
   end

   // Val2: memory offset, rotated immediate, or shifted register.
   logic [4:0]       sh_amt;
   logic [4:0]       rot_amt;
   logic [WIDTH-1:0] imm32;
   logic [WIDTH-1:0] asr_val;

   assign sh_amt  = shift_operand_in[11:7];
   assign rot_amt = {shift_operand_in[11:8], 1'b0};
   assign imm32   = {24'b0, shift_operand_in[7:0]};
   assign asr_val = $signed(rm_f) >>> sh_amt;

   // A rotate of 0 shifts the left half by 32, which yields 0 and passes the value through.
   always_comb begin
      val2 = rm_f;
      if (mem_r_en_in || mem_w_en_in) begin
         val2 = {20'b0, shift_operand_in};
      end else if (imm_in) begin
         val2 = (imm32 >> rot_amt) | (imm32 << (6'd32 - {1'b0, rot_amt}));
      end else begin
         case (shift_operand_in[6:5])
            2'b00:   val2 = rm_f << sh_amt;
            2'b01:   val2 = rm_f >> sh_amt;
            2'b10:   val2 = asr_val;
            default: val2 = (rm_f >> sh_amt) | (rm_f << (6'd32 - {1'b0, sh_amt}));
         endcase
      end
   end

   // ALU; C and V default to the decode-time snapshot for non-arithmetic ops.
   logic [WIDTH:0] add_sum, sub_diff;
   logic           add_cin, sub_bin;

   assign add_cin  = (exe_cmd_in == OpAdc) ? status_in[1] : 1'b0;
   assign sub_bin  = (exe_cmd_in == OpSbc) ? ~status_in[1] : 1'b0;
   assign add_sum  = {1'b0, rn_f} + {1'b0, val2} + {{WIDTH{1'b0}}, add_cin};
   assign sub_diff = {1'b0, rn_f} - {1'b0, val2} - {{WIDTH{1'b0}}, sub_bin};

   always_comb begin
      alu_out = '0;
      alu_c   = status_in[1];
      alu_v   = status_in[0];
      case (exe_cmd_in)
         OpMov: alu_out = val2;
         OpMvn: alu_out = ~val2;
         OpAdd, OpAdc: begin
            alu_out = add_sum[WIDTH-1:0];
            alu_c   = add_sum[WIDTH];
            alu_v   = (rn_f[WIDTH-1] == val2[WIDTH-1]) &&
                      (add_sum[WIDTH-1] != rn_f[WIDTH-1]);
         end
         OpSub, OpSbc: begin
            alu_out = sub_diff[WIDTH-1:0];
            alu_c   = ~sub_diff[WIDTH];
            alu_v   = (rn_f[WIDTH-1] != val2[WIDTH-1]) &&
                      (sub_diff[WIDTH-1] != rn_f[WIDTH-1]);
         end
         OpAnd: alu_out = rn_f & val2;
         OpOrr: alu_out = rn_f | val2;
         OpEor: alu_out = rn_f ^ val2;
         default: alu_out = '0;
      endcase
   end

   // Result and flags presented to the pipeline register; a finished multiply overrides the ALU.
   always_comb begin
      exe_res = alu_out;
      flags   = {alu_out[WIDTH-1], (alu_out == '0), alu_c, alu_v};
      if (mul_done) begin
         exe_res = mul_res;
         flags   = {mul_res[WIDTH-1], (mul_res == '0), status_q[1:0]};
      end
   end

`ifdef MUL_EN
   localparam logic [3:0] OpMul = 4'b1010;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

   mul_state_e       state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             busy;

   // Multiplier state and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   // Shift-add sequencing; freeze holds every register in place.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      busy     = 1'b0;
      mul_done = 1'b0;
      case (state_q)
         StIdle: begin
            if (exe_cmd_in == OpMul) begin
               busy = 1'b1;
               if (!freeze) begin
                  mcand_d  = rn_f;
                  mplier_d = val2;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = StBusy;
               end
            end
         end
         StBusy: begin
            busy = 1'b1;
            if (!freeze) begin
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               if (cnt_q == 5'd31) begin
                  cnt_d   = '0;
                  state_d = StDone;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         StDone: begin
            mul_done = 1'b1;
            if (!freeze) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign mul_busy = busy;
   assign mul_res  = acc_q;
`else
   assign mul_busy = 1'b0;
   assign mul_done = 1'b0;
   assign mul_res  = '0;
`endif

   assign pipe_load = !freeze && !mul_busy;

   // EXE/MEM pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_res_q  <= '0;
         st_val_q   <= '0;
         dest_q     <= '0;
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         mem_w_en_q <= 1'b0;
      end else if (pipe_load) begin
         alu_res_q  <= exe_res;
         st_val_q   <= rm_f;
         dest_q     <= dest_in;
         wb_en_q    <= wb_en_in;
         mem_r_en_q <= mem_r_en_in;
         mem_w_en_q <= mem_w_en_in;
      end
   end

   // Architectural NZCV register, written only by flag-setting instructions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_q <= '0;
      end else if (s_in && pipe_load) begin
         status_q <= flags;
      end
   end

   assign status_out = status_q;
   assign alu_res    = alu_res_q;
   assign st_val     = st_val_q;
   assign dest       = dest_q;
   assign wb_en      = wb_en_q;
   assign mem_r_en   = mem_r_en_q;
   assign mem_w_en   = mem_w_en_q;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases with literal results plus randomized
// instructions compared against an arithmetic reference model every cycle.
module tb_exe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic [31:0] pc_in;
   logic        b_in, s_in, mem_r_en_in, mem_w_en_in, wb_en_in, imm_in;
   logic [3:0]  exe_cmd_in, status_in, dest_in;
   logic [23:0] signed_imm_24_in;
   logic [11:0] shift_operand_in;
   logic [31:0] val_rn_in, val_rm_in, wb_value;
   logic [1:0]  fwd_sel_rn, fwd_sel_rm;
   logic        branch_taken;
   logic [31:0] branch_addr, alu_res, st_val;
   logic [3:0]  status_out, dest;
   logic        wb_en, mem_r_en, mem_w_en, mul_busy;

   exe_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in), .b_in(b_in), .s_in(s_in),
      .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
      .imm_in(imm_in), .exe_cmd_in(exe_cmd_in), .status_in(status_in),
      .signed_imm_24_in(signed_imm_24_in), .shift_operand_in(shift_operand_in),
      .dest_in(dest_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
      .fwd_sel_rn(fwd_sel_rn), .fwd_sel_rm(fwd_sel_rm), .wb_value(wb_value),
      .branch_taken(branch_taken), .branch_addr(branch_addr), .status_out(status_out),
      .alu_res(alu_res), .st_val(st_val), .dest(dest), .wb_en(wb_en),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mul_busy(mul_busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference state of the registered outputs.
   logic [31:0] m_alu, m_st;
   logic [3:0]  m_dest, m_status;
   logic        m_wb, m_mr, m_mw;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned r);
      logic [63:0] d;
      d = {x, x} >> r;
      return d[31:0];
   endfunction

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_val);
      if (sel == 2'b01) return m_alu;
      if (sel == 2'b10) return wb_value;
      return reg_val;
   endfunction

   function automatic logic [31:0] ref_val2(input logic [31:0] rm);
      logic signed [31:0] srm;
      int unsigned amt;
      srm = rm;
      amt = shift_operand_in[11:7];
      if (mem_r_en_in || mem_w_en_in) return {20'b0, shift_operand_in};
      if (imm_in) return ror32({24'b0, shift_operand_in[7:0]}, 2 * shift_operand_in[11:8]);
      case (shift_operand_in[6:5])
         2'b00:   return rm << amt;
         2'b01:   return rm >> amt;
         2'b10:   return srm >>> amt;
         default: return ror32(rm, amt);
      endcase
   endfunction

   // Arithmetic from wide integers: carry/borrow and overflow are range checks.
   task automatic ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] st, output logic [31:0] r, output logic [3:0] f);
      longint ua, ub, sa, sb, us, ss, k;
      int     ia, ib;
      logic   c, v;
      ua = {32'b0, a};
      ub = {32'b0, b};
      ia = a;
      ib = b;
      sa = ia;
      sb = ib;
      c  = st[1];
      v  = st[0];
      r  = 32'h0;
      case (cmd)
         4'd1: r = b;
         4'd9: r = ~b;
         4'd2, 4'd3: begin
            k  = (cmd == 4'd3) ? longint'(st[1]) : 0;
            us = ua + ub + k;
            ss = sa + sb + k;
            r  = us[31:0];
            c  = us > 64'sd4294967295;
            v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         4'd4, 4'd5: begin
            k  = (cmd == 4'd5) ? longint'(!st[1]) : 0;
            us = ua - ub - k;
            ss = sa - sb - k;
            r  = us[31:0];
            c  = us >= 0;
            v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         default: r = 32'h0;
      endcase
      f = {r[31], r == 32'h0, c, v};
   endtask

   task automatic check_regs();
      chk("alu_res", alu_res, m_alu);
      chk("st_val", st_val, m_st);
      chk("dest", {28'b0, dest}, {28'b0, m_dest});
      chk("wb_en", {31'b0, wb_en}, {31'b0, m_wb});
      chk("mem_r_en", {31'b0, mem_r_en}, {31'b0, m_mr});
      chk("mem_w_en", {31'b0, mem_w_en}, {31'b0, m_mw});
      chk("status_out", {28'b0, status_out}, {28'b0, m_status});
   endtask

   // One clock: check combinational outputs, predict the edge, check registered outputs.
   task automatic tick();
      logic [31:0] rnf, rmf, v2, r, exp_ba;
      logic [3:0]  f;
      int          off;
      #1;
      off    = {{8{signed_imm_24_in[23]}}, signed_imm_24_in};
      exp_ba = pc_in + 32'(off * 4);
      chk("branch_taken", {31'b0, branch_taken}, {31'b0, b_in});
      chk("branch_addr", branch_addr, exp_ba);
`ifndef MUL_EN
      chk("mul_busy", {31'b0, mul_busy}, 32'h0);
`endif
      rnf = fwd(fwd_sel_rn, val_rn_in);
      rmf = fwd(fwd_sel_rm, val_rm_in);
      v2  = ref_val2(rmf);
      ref_alu(exe_cmd_in, rnf, v2, status_in, r, f);
      @(posedge clk);
      if (!freeze) begin
         m_alu  = r;
         m_st   = rmf;
         m_dest = dest_in;
         m_wb   = wb_en_in;
         m_mr   = mem_r_en_in;
         m_mw   = mem_w_en_in;
         if (s_in) m_status = f;
      end
      #1;
      check_regs();
      @(negedge clk);
   endtask

   task automatic set_nop();
      freeze = 0; pc_in = 0; b_in = 0; s_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
      wb_en_in = 0; imm_in = 0; exe_cmd_in = 0; status_in = 0; signed_imm_24_in = 0;
      shift_operand_in = 0; dest_in = 0; val_rn_in = 0; val_rm_in = 0; wb_value = 0;
      fwd_sel_rn = 0; fwd_sel_rm = 0;
   endtask

   task automatic set_random();
      logic [3:0] cmd;
      freeze           = ($urandom_range(0, 4) == 0);
      pc_in            = $urandom;
      b_in             = $urandom_range(0, 1);
      s_in             = $urandom_range(0, 1);
      mem_r_en_in      = ($urandom_range(0, 3) == 0);
      mem_w_en_in      = ($urandom_range(0, 3) == 0);
      wb_en_in         = $urandom_range(0, 1);
      imm_in           = $urandom_range(0, 1);
      cmd              = 4'($urandom_range(0, 15));
`ifdef MUL_EN
      if (cmd == 4'd10) cmd = 4'd2;
`endif
      exe_cmd_in       = cmd;
      status_in        = 4'($urandom);
      signed_imm_24_in = 24'($urandom);
      shift_operand_in = 12'($urandom);
      dest_in          = 4'($urandom);
      val_rn_in        = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      val_rm_in        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      wb_value         = $urandom;
      fwd_sel_rn       = 2'($urandom);
      fwd_sel_rm       = 2'($urandom);
   endtask

   task automatic clear_model();
      m_alu = 0; m_st = 0; m_dest = 0; m_status = 0; m_wb = 0; m_mr = 0; m_mw = 0;
   endtask

   initial begin
      set_nop();
      clear_model();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_regs();
      chk("reset alu_res", alu_res, 32'h0);
      chk("reset status", {28'b0, status_out}, 32'h0);
      rst = 1'b0;

      // ADD with Rm forwarded from writeback.
      set_nop(); exe_cmd_in = 4'd2; val_rn_in = 5; val_rm_in = 99; fwd_sel_rm = 2'b10;
      wb_value = 7; dest_in = 4'd3; wb_en_in = 1; tick();
      chk("add alu_res", alu_res, 32'd12);
      chk("add dest", {28'b0, dest}, 32'd3);
      chk("add wb_en", {31'b0, wb_en}, 32'd1);
      chk("add st_val", st_val, 32'd7);

      // SUBS overflowing from most-negative.
      set_nop(); exe_cmd_in = 4'd4; s_in = 1; val_rn_in = 32'h8000_0000; imm_in = 1;
      shift_operand_in = 12'h001; tick();
      chk("subs alu_res", alu_res, 32'h7FFF_FFFF);
      chk("subs nzcv", {28'b0, status_out}, 32'b0011);

      // MOV rotated immediate; status untouched without S.
      set_nop(); exe_cmd_in = 4'd1; imm_in = 1; shift_operand_in = 12'h2FF; tick();
      chk("mov imm", alu_res, 32'hF000_000F);
      chk("mov keeps nzcv", {28'b0, status_out}, 32'b0011);

      // Register shifts: LSR 4, ASR 4, ROR 8.
      set_nop(); exe_cmd_in = 4'd1; val_rm_in = 32'hF0; shift_operand_in = 12'h220; tick();
      chk("lsr", alu_res, 32'h0000_000F);
      set_nop(); exe_cmd_in = 4'd1; val_rm_in = 32'h8000_0000; shift_operand_in = 12'h240;
      tick();
      chk("asr", alu_res, 32'hF800_0000);
      set_nop(); exe_cmd_in = 4'd1; val_rm_in = 32'h1234_5678; shift_operand_in = 12'h460;
      tick();
      chk("ror", alu_res, 32'h7812_3456);

      // LDR address generation.
      set_nop(); exe_cmd_in = 4'd2; mem_r_en_in = 1; shift_operand_in = 12'h004;
      val_rn_in = 32'h100; tick();
      chk("ldr addr", alu_res, 32'h104);

      // Three frozen cycles hold everything, including the forwarded alu_res path.
      set_nop(); freeze = 1; exe_cmd_in = 4'd2; s_in = 1; val_rn_in = 5; fwd_sel_rn = 2'b01;
      dest_in = 4'd9;
      for (int i = 0; i < 3; i++) tick();
      chk("freeze alu_res", alu_res, 32'h104);
      chk("freeze nzcv", {28'b0, status_out}, 32'b0011);
      chk("freeze mem_r_en", {31'b0, mem_r_en}, 32'd1);

      // Branch target with a negative offset.
      set_nop(); b_in = 1; pc_in = 32'h20; signed_imm_24_in = 24'hFFFFFE; #1;
      chk("branch_addr lit", branch_addr, 32'h18);
      chk("branch_taken lit", {31'b0, branch_taken}, 32'd1);
      tick();

`ifndef MUL_EN
      // Opcode 1010 without the multiplier is an undefined op: result 0, Z set.
      set_nop(); exe_cmd_in = 4'd10; s_in = 1; val_rn_in = 3; val_rm_in = 4; tick();
      chk("op1010 res", alu_res, 32'h0);
      chk("op1010 nzcv", {28'b0, status_out}, 32'b0100);
`endif

      for (int i = 0; i < 400; i++) begin
         set_random();
         tick();
      end

      // Asynchronous reset between clock edges.
      #2 rst = 1'b1;
      #1;
      clear_model();
      chk("async rst alu_res", alu_res, 32'h0);
      chk("async rst st_val", st_val, 32'h0);
      chk("async rst status", {28'b0, status_out}, 32'h0);
      chk("async rst ctl", {24'b0, dest, wb_en, mem_r_en, mem_w_en, 1'b0}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 100; i++) begin
         set_random();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
